// File: rtl/data_memory_sized.sv
// MEM-stage data RAM: byte-addressed sized stores/loads with alignment checking,
// plus a debug dump engine that streams every word over a valid/ready handshake.
module data_memory_sized #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DUMP_ENABLE = 1,
   localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_wr,
   input  logic                  i_rd,
   input  logic [1:0]            i_size,
   input  logic                  i_unsigned,
   input  logic [31:0]           i_data,
   output logic [31:0]           o_data,
   output logic                  o_misaligned,
   output logic                  o_busy,
   input  logic                  i_dbg_start,
   input  logic                  i_dbg_ready,
   output logic                  o_dbg_valid,
   output logic [IDX_W-1:0]      o_dbg_addr,
   output logic [31:0]           o_dbg_data,
   output logic                  o_dbg_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_SEND  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

   logic [31:0]      r_mem [DEPTH_WORDS];
   logic [1:0]       r_state;
   logic [IDX_W-1:0] r_idx;

   logic [IDX_W-1:0] w_idx;
   logic [1:0]       w_lane;
   logic             w_busy;
   logic             w_mis;
   logic             w_fault;
   logic             w_do_wr;
   logic             w_do_rd;
   logic [IDX_W-1:0] w_rd_idx;
   logic [31:0]      w_rd_word;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_load;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic             w_unused;

   // Address bits above the word index are ignored, so the RAM aliases modulo its depth.
   assign w_idx    = i_addr[IDX_W+1:2];
   assign w_lane   = i_addr[1:0];
   assign w_unused = &{1'b0, i_addr[ADDR_WIDTH-1:IDX_W+2]};

   assign w_busy   = (r_state != S_IDLE);

   always_comb begin
      w_mis = 1'b0;
      case (i_size)
         SZ_BYTE: w_mis = 1'b0;
         SZ_HALF: w_mis = i_addr[0];
         SZ_WORD: w_mis = (w_lane != 2'b00);
         default: w_mis = 1'b1;
      endcase
   end

   assign w_fault = (i_rd | i_wr) & ~w_busy & w_mis;
   assign w_do_wr = i_wr & ~w_busy & ~w_mis & i_rst;
   assign w_do_rd = i_rd & ~w_busy & ~w_mis;

   // CPU and dump engine never read in the same cycle, so they share one read port.
   assign w_rd_idx  = w_busy ? r_idx : w_idx;
   assign w_rd_word = r_mem[w_rd_idx];

   assign w_byte = w_rd_word[{w_lane, 3'b000} +: 8];
   assign w_half = i_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

   always_comb begin
      w_load = 32'h0;
      case (i_size)
         SZ_BYTE: w_load = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         SZ_HALF: w_load = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         SZ_WORD: w_load = w_rd_word;
         default: w_load = 32'h0;
      endcase
   end

   // Store data is replicated across lanes; the byte enables pick the lanes that land.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = i_data;
      case (i_size)
         SZ_BYTE: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{i_data[7:0]}};
         end
         SZ_HALF: begin
            w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_data[15:0]}};
         end
         SZ_WORD: begin
            w_be    = 4'b1111;
            w_wdata = i_data;
         end
         default: begin
            w_be    = 4'b0000;
            w_wdata = i_data;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_do_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         o_data       <= 32'h0;
         o_misaligned <= 1'b0;
         o_dbg_addr   <= '0;
         o_dbg_data   <= 32'h0;
      end else begin
         o_data       <= w_do_rd ? w_load : 32'h0;
         o_misaligned <= w_fault;
         case (r_state)
            S_IDLE: begin
               if ((DUMP_ENABLE != 0) && i_dbg_start) begin
                  r_state <= S_FETCH;
                  r_idx   <= '0;
               end
            end
            S_FETCH: begin
               o_dbg_data <= w_rd_word;
               o_dbg_addr <= r_idx;
               r_state    <= S_SEND;
            end
            S_SEND: begin
               if (i_dbg_ready) begin
                  if (r_idx == LAST_IDX) begin
                     r_state <= S_DONE;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= S_FETCH;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy      = w_busy;
   assign o_dbg_valid = (r_state == S_SEND);
   assign o_dbg_done  = (r_state == S_DONE);

endmodule
